control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; forces IDLE.
REQ-003 SHALL have ports: run  in  1  level; permits instruction fetch.
REQ-004 SHALL have ports: mem_ready  in  1  memory read data valid on MDR input.
REQ-005 SHALL have ports: ir  in  32  current IR contents fed back from datapath.
REQ-006 SHALL have ports: PC_select, ZLO_select, ZHI_select, MDR_select  out  1 each  bus drive enables.
REQ-007 SHALL have ports: MAR_select_write, Y_select_write, ZLO_select_write, ZHI_select_write, MDR_select_write, IR_write, PC_write, HI_write, LO_write  out  1 each  register loads.
REQ-008 SHALL have ports: Increment_PC, Read  out  1 each; alu_op  out  5  ALU opcode.
REQ-009 SHALL have ports: rf_out_sel  out  4, rf_out_en  out  1; RF_write  out  4, RF_enable  out  1.
REQ-010 SHALL have ports: halted  out  1  sequencer stopped on HALT; busy  out  1  state not IDLE/HALT.

Function
REQ-011 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; state registered, outputs combinational decode of state and ir.
REQ-012 SHALL decode ir: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-013 SHALL leave IDLE for T0 when run=1; otherwise remain in IDLE.
REQ-014 SHALL in T0 assert PC_select, MAR_select_write, Increment_PC, ZLO_select_write; next T1.
REQ-015 SHALL in T1 assert ZLO_select, Read, MDR_select_write; PC_write only in the cycle mem_ready=1; stay in T1 while mem_ready=0, advance to T2 when mem_ready=1.
REQ-016 SHALL in T2 assert MDR_select, IR_write; next T3.
REQ-017 SHALL in T3 for ALU opcodes ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000 (and MUL 01111, see REQ-026) assert rf_out_en, rf_out_sel=Rb, Y_select_write; next T4.
REQ-018 SHALL in T4 assert rf_out_en, rf_out_sel=Rc, alu_op=opcode, ZLO_select_write (plus ZHI_select_write for MUL); next T5.
REQ-019 SHALL in T5 for non-MUL assert ZLO_select, RF_write=Ra, RF_enable; next T0 if run=1 else IDLE.
REQ-020 SHALL treat NOP 11010 and every undefined opcode as NOP: T3 produces no outputs, next T0 if run=1 else IDLE.
REQ-021 SHALL on HALT 11011 go T3 -> HALT; HALT is left only by reset; halted=1 in HALT.
REQ-022 SHALL drive alu_op=0, rf_out_sel=0, RF_write=0 and every 1-bit output 0 in any state/cycle not listed.
REQ-023 SHALL complete an in-flight instruction when run falls mid-instruction, then enter IDLE.
REQ-024 SHALL never assert two bus drive enables (PC/ZLO/ZHI/MDR_select, rf_out_en) in the same cycle.

Reset
REQ-025 SHALL on reset=1 immediately (no clock) enter IDLE and drive every output 0, including mid-instruction and during a T1 wait; first fetch begins the rising edge after reset=0 with run=1.

Configuration
REQ-026 SHALL, with SEQ_MULDIV_EN defined, execute MUL 01111 as T0-T4, T5 (ZHI_select, HI_write), T6 (ZLO_select, LO_write), then T0/IDLE; without SEQ_MULDIV_EN, MUL is undefined (NOP per REQ-020) and state T6 is never entered.

Verification
REQ-027 SHALL cover: reset, run=1, mem_ready=1, ir=0x2A1B8000 (AND R4,R3,R7) -> T0..T5 in 6 cycles; T3 rf_out_sel=3, T4 rf_out_sel=7 alu_op=00101, T5 RF_write=4 RF_enable=1.
REQ-028 SHALL cover: mem_ready held 0 for 3 cycles in T1 -> Read/MDR_select_write held 4 cycles, PC_write exactly one cycle, then T2.
REQ-029 SHALL cover: ir opcode 11011 -> HALT after T3, halted=1 for 10+ cycles despite run=1; reset -> IDLE, halted=0.
REQ-030 SHALL cover: run dropped during T4 of an ADD -> T5 completes, then IDLE, busy=0; no T0.
REQ-031 SHALL cover: reset pulsed asynchronously mid-T4 -> all outputs 0 before next clock edge, state IDLE.
REQ-032 SHALL cover: MUL 0x7A1B8000 with SEQ_MULDIV_EN -> T5 HI_write=1, T6 LO_write=1; without it -> NOP, next state T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch (T0-T2), then decode/execute (T3-T6) of the current IR.
// Optional build macro SEQ_MULDIV_EN adds the two-cycle MUL write-back (HI then LO) through T6.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PC_select,
    output logic        ZLO_select,
    output logic        ZHI_select,
    output logic        MDR_select,
    output logic        MAR_select_write,
    output logic        Y_select_write,
    output logic        ZLO_select_write,
    output logic        ZHI_select_write,
    output logic        MDR_select_write,
    output logic        IR_write,
    output logic        PC_write,
    output logic        HI_write,
    output logic        LO_write,
    output logic        Increment_PC,
    output logic        Read,
    output logic [4:0]  alu_op,
    output logic [3:0]  rf_out_sel,
    output logic        rf_out_en,
    output logic [3:0]  RF_write,
    output logic        RF_enable,
    output logic        halted,
    output logic        busy
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0] state, state_nxt;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_mul, is_alu, is_halt;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

`ifdef SEQ_MULDIV_EN
    localparam logic [4:0] OP_MUL = 5'b01111;
    assign is_mul = (opcode == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    // ADD..SHL are contiguous opcodes; anything else that is not MUL/HALT decodes as NOP
    assign is_alu  = ((opcode >= OP_ADD) && (opcode <= OP_SHL)) || is_mul;
    assign is_halt = (opcode == OP_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // run is only sampled at instruction boundaries so a fall mid-instruction lets it finish
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (run) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   if (mem_ready) state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (is_halt)     state_nxt = S_HALT;
                else if (is_alu) state_nxt = S_T4;
                else             state_nxt = run ? S_T0 : S_IDLE;
            end
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = is_mul ? S_T6 : (run ? S_T0 : S_IDLE);
            S_T6:   state_nxt = run ? S_T0 : S_IDLE;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PC_select        = 1'b0;
        ZLO_select       = 1'b0;
        ZHI_select       = 1'b0;
        MDR_select       = 1'b0;
        MAR_select_write = 1'b0;
        Y_select_write   = 1'b0;
        ZLO_select_write = 1'b0;
        ZHI_select_write = 1'b0;
        MDR_select_write = 1'b0;
        IR_write         = 1'b0;
        PC_write         = 1'b0;
        HI_write         = 1'b0;
        LO_write         = 1'b0;
        Increment_PC     = 1'b0;
        Read             = 1'b0;
        alu_op           = 5'd0;
        rf_out_sel       = 4'd0;
        rf_out_en        = 1'b0;
        RF_write         = 4'd0;
        RF_enable        = 1'b0;
        case (state)
            S_T0: begin
                PC_select        = 1'b1;
                MAR_select_write = 1'b1;
                Increment_PC     = 1'b1;
                ZLO_select_write = 1'b1;
            end
            S_T1: begin
                // Z holds PC+1; PC is loaded once, on the cycle the read completes
                ZLO_select       = 1'b1;
                Read             = 1'b1;
                MDR_select_write = 1'b1;
                PC_write         = mem_ready;
            end
            S_T2: begin
                MDR_select = 1'b1;
                IR_write   = 1'b1;
            end
            S_T3: begin
                if (is_alu) begin
                    rf_out_en      = 1'b1;
                    rf_out_sel     = rb;
                    Y_select_write = 1'b1;
                end
            end
            S_T4: begin
                rf_out_en        = 1'b1;
                rf_out_sel       = rc;
                alu_op           = opcode;
                ZLO_select_write = 1'b1;
                ZHI_select_write = is_mul;
            end
            S_T5: begin
                if (is_mul) begin
                    ZHI_select = 1'b1;
                    HI_write   = 1'b1;
                end else begin
                    ZLO_select = 1'b1;
                    RF_write   = ra;
                    RF_enable  = 1'b1;
                end
            end
            S_T6: begin
                ZLO_select = 1'b1;
                LO_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state == S_HALT);
    assign busy   = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer; all outputs packed into one 32-bit word per check.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [31:0] ir;
    logic PC_select, ZLO_select, ZHI_select, MDR_select;
    logic MAR_select_write, Y_select_write, ZLO_select_write, ZHI_select_write;
    logic MDR_select_write, IR_write, PC_write, HI_write, LO_write;
    logic Increment_PC, Read, rf_out_en, RF_enable, halted, busy;
    logic [4:0] alu_op;
    logic [3:0] rf_out_sel, RF_write;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PC_select(PC_select), .ZLO_select(ZLO_select), .ZHI_select(ZHI_select),
        .MDR_select(MDR_select), .MAR_select_write(MAR_select_write),
        .Y_select_write(Y_select_write), .ZLO_select_write(ZLO_select_write),
        .ZHI_select_write(ZHI_select_write), .MDR_select_write(MDR_select_write),
        .IR_write(IR_write), .PC_write(PC_write), .HI_write(HI_write), .LO_write(LO_write),
        .Increment_PC(Increment_PC), .Read(Read), .alu_op(alu_op),
        .rf_out_sel(rf_out_sel), .rf_out_en(rf_out_en), .RF_write(RF_write),
        .RF_enable(RF_enable), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] outv;
    assign outv = {PC_select, ZLO_select, ZHI_select, MDR_select, MAR_select_write,
                   Y_select_write, ZLO_select_write, ZHI_select_write, MDR_select_write,
                   IR_write, PC_write, HI_write, LO_write, Increment_PC, Read,
                   alu_op, rf_out_sel, rf_out_en, RF_write, RF_enable, halted, busy};

    localparam logic [31:0] PC_SEL  = 32'h8000_0000;
    localparam logic [31:0] ZLO_SEL = 32'h4000_0000;
    localparam logic [31:0] ZHI_SEL = 32'h2000_0000;
    localparam logic [31:0] MDR_SEL = 32'h1000_0000;
    localparam logic [31:0] MAR_W   = 32'h0800_0000;
    localparam logic [31:0] Y_W     = 32'h0400_0000;
    localparam logic [31:0] ZLO_W   = 32'h0200_0000;
    localparam logic [31:0] ZHI_W   = 32'h0100_0000;
    localparam logic [31:0] MDR_W   = 32'h0080_0000;
    localparam logic [31:0] IR_W    = 32'h0040_0000;
    localparam logic [31:0] PC_W    = 32'h0020_0000;
    localparam logic [31:0] HI_W    = 32'h0010_0000;
    localparam logic [31:0] LO_W    = 32'h0008_0000;
    localparam logic [31:0] INC_PC  = 32'h0004_0000;
    localparam logic [31:0] RD      = 32'h0002_0000;
    localparam logic [31:0] RF_OE   = 32'h0000_0080;
    localparam logic [31:0] RF_EN   = 32'h0000_0004;
    localparam logic [31:0] HALTED  = 32'h0000_0002;
    localparam logic [31:0] BUSY    = 32'h0000_0001;

    localparam logic [31:0] E_T0     = PC_SEL | MAR_W | INC_PC | ZLO_W | BUSY;
    localparam logic [31:0] E_T1     = ZLO_SEL | RD | MDR_W | PC_W | BUSY;
    localparam logic [31:0] E_T1WAIT = ZLO_SEL | RD | MDR_W | BUSY;
    localparam logic [31:0] E_T2     = MDR_SEL | IR_W | BUSY;

    function automatic logic [31:0] f_sel(input logic [3:0] r);
        return {20'd0, r, 8'd0};
    endfunction
    function automatic logic [31:0] f_alu(input logic [4:0] op);
        return {15'd0, op, 12'd0};
    endfunction
    function automatic logic [31:0] f_rfw(input logic [3:0] r);
        return {25'd0, r, 3'd0};
    endfunction

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input string tag);
        step; chk({tag, "_t0"}, outv, E_T0);
        step; chk({tag, "_t1"}, outv, E_T1);
        step; chk({tag, "_t2"}, outv, E_T2);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        #3 chk("reset", outv, 32'd0);
        @(negedge clk) reset = 1'b0;
        step; chk("idle_norun", outv, 32'd0);

        // AND R4,R3,R7
        run = 1'b1; mem_ready = 1'b1; ir = 32'h2A1B8000;
        fetch_chk("and");
        step; chk("and_t3", outv, RF_OE | f_sel(4'd3) | Y_W | BUSY);
        step; chk("and_t4", outv, RF_OE | f_sel(4'd7) | f_alu(5'b00101) | ZLO_W | BUSY);
        run = 1'b0;
        step; chk("and_t5", outv, ZLO_SEL | f_rfw(4'd4) | RF_EN | BUSY);
        step; chk("and_idle", outv, 32'd0);

        // memory wait in T1
        run = 1'b1; mem_ready = 1'b0;
        step; chk("wait_t0", outv, E_T0);
        for (int i = 0; i < 3; i++) begin
            step; chk("wait_t1_hold", outv, E_T1WAIT);
        end
        step; mem_ready = 1'b1; #1;
        chk("wait_t1_ready", outv, E_T1);
        run = 1'b0;
        step; chk("wait_t2", outv, E_T2);
        repeat (3) step;
        step; chk("wait_idle", outv, 32'd0);

        // ADD R1,R2,R3 with run dropped in T4
        run = 1'b1; ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        fetch_chk("add");
        step; chk("add_t3", outv, RF_OE | f_sel(4'd2) | Y_W | BUSY);
        step; run = 1'b0;
        chk("add_t4", outv, RF_OE | f_sel(4'd3) | f_alu(5'b00011) | ZLO_W | BUSY);
        step; chk("add_t5", outv, ZLO_SEL | f_rfw(4'd1) | RF_EN | BUSY);
        step; chk("add_idle", outv, 32'd0);
        step; chk("add_no_t0", outv, 32'd0);

        // asynchronous reset mid-T4
        run = 1'b1; ir = 32'h2A1B8000;
        repeat (5) step;
        chk("rst_pre_t4", outv, RF_OE | f_sel(4'd7) | f_alu(5'b00101) | ZLO_W | BUSY);
        #1 reset = 1'b1;
        #1 chk("rst_async_t4", outv, 32'd0);
        run = 1'b0; reset = 1'b0;
        step; chk("rst_t4_idle", outv, 32'd0);

        // asynchronous reset during a T1 wait
        run = 1'b1; mem_ready = 1'b0;
        step; step; step;
        chk("rst_pre_t1", outv, E_T1WAIT);
        #1 reset = 1'b1;
        #1 chk("rst_async_t1", outv, 32'd0);
        run = 1'b0; reset = 1'b0; mem_ready = 1'b1;
        step; chk("rst_t1_idle", outv, 32'd0);

        // NOP then an undefined opcode
        run = 1'b1; ir = {5'b11010, 27'd0};
        fetch_chk("nop");
        step; chk("nop_t3", outv, BUSY);
        ir = {5'b11111, 4'd5, 4'd6, 4'd7, 15'd0};
        step; chk("nop_to_t0", outv, E_T0);
        run = 1'b0;
        step; step; step; chk("undef_t3", outv, BUSY);
        step; chk("undef_idle", outv, 32'd0);

        // MUL R4,R3,R7
        run = 1'b1; ir = 32'h7A1B8000;
        repeat (3) step;
        step;
`ifdef SEQ_MULDIV_EN
        chk("mul_t3", outv, RF_OE | f_sel(4'd3) | Y_W | BUSY);
        step; chk("mul_t4", outv, RF_OE | f_sel(4'd7) | f_alu(5'b01111) | ZLO_W | ZHI_W | BUSY);
        step; chk("mul_t5", outv, ZHI_SEL | HI_W | BUSY);
        step; chk("mul_t6", outv, ZLO_SEL | LO_W | BUSY);
`else
        chk("mul_nop_t3", outv, BUSY);
`endif
        step; chk("mul_next_t0", outv, E_T0);
        run = 1'b0;
        #1 reset = 1'b1;
        #1 reset = 1'b0;

        // HALT is sticky until reset
        run = 1'b1; ir = {5'b11011, 27'd0};
        fetch_chk("halt");
        step; chk("halt_t3", outv, BUSY);
        step; chk("halt_enter", outv, HALTED);
        for (int i = 0; i < 10; i++) begin
            step; chk("halt_hold", outv, HALTED);
        end
        #1 reset = 1'b1;
        #1 chk("halt_reset", outv, 32'd0);
        run = 1'b0; reset = 1'b0;
        step; chk("halt_after_idle", outv, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
